// File: rtl/frontend_rat_ckpt_pkg.sv
// Shared sizes and index types for the rename alias table.
package frontend_rat_ckpt_pkg;
    localparam int WIDTH       = 2;
    localparam int REG_NUM     = 32;
    localparam int REG_SEL     = 5;
    localparam int PHY_REG_SEL = 6;
    localparam int NUM_CKPT    = 4;
    localparam int CKPT_SEL    = 2;

    typedef logic [REG_SEL-1:0]     arch_t;
    typedef logic [PHY_REG_SEL-1:0] phys_t;
    typedef logic [CKPT_SEL-1:0]    ckpt_t;
endpackage

// File: rtl/frontend_rat_ckpt_if.sv
// Rename, branch-recovery and commit signals between the pipeline and the alias table.
interface frontend_rat_ckpt_if;
    import frontend_rat_ckpt_pkg::*;

    logic [WIDTH-1:0]             ren_valid;
    logic [WIDTH*REG_SEL-1:0]     rs1;
    logic [WIDTH*REG_SEL-1:0]     rs2;
    logic [WIDTH-1:0]             uses_rs1;
    logic [WIDTH-1:0]             uses_rs2;
    logic [WIDTH*REG_SEL-1:0]     dst;
    logic [WIDTH-1:0]             wr_reg;
    logic [WIDTH*PHY_REG_SEL-1:0] phy_dst;
    logic [WIDTH-1:0]             is_branch;
    logic                         ren_ready;
    logic [WIDTH*PHY_REG_SEL-1:0] phy_src1;
    logic [WIDTH*PHY_REG_SEL-1:0] phy_src2;
    logic [WIDTH*PHY_REG_SEL-1:0] phy_ori_dst;
    ckpt_t                        ckpt_id;
    logic                         br_resolve;
    ckpt_t                        br_resolve_id;
    logic                         br_mispredict;
    ckpt_t                        br_mispredict_id;
    logic [WIDTH-1:0]             cm_valid;
    logic [WIDTH*REG_SEL-1:0]     cm_dst;
    logic [WIDTH*PHY_REG_SEL-1:0] cm_phy;
    logic                         flush;
    logic                         ckpt_full;

    modport master (
        output ren_valid, rs1, rs2, uses_rs1, uses_rs2, dst, wr_reg, phy_dst, is_branch,
        output br_resolve, br_resolve_id, br_mispredict, br_mispredict_id,
        output cm_valid, cm_dst, cm_phy, flush,
        input  ren_ready, phy_src1, phy_src2, phy_ori_dst, ckpt_id, ckpt_full
    );

    modport slave (
        input  ren_valid, rs1, rs2, uses_rs1, uses_rs2, dst, wr_reg, phy_dst, is_branch,
        input  br_resolve, br_resolve_id, br_mispredict, br_mispredict_id,
        input  cm_valid, cm_dst, cm_phy, flush,
        output ren_ready, phy_src1, phy_src2, phy_ori_dst, ckpt_id, ckpt_full
    );
endinterface

// File: rtl/frontend_rat_ckpt_group_bypass.sv
// Looks up one arch register through the in-flight rename group: the highest enabled
// lane whose destination matches overrides the stored mapping.
module rat_group_bypass
    import frontend_rat_ckpt_pkg::*;
(
    input  arch_t                        query,
    input  phys_t                        map_val,
    input  logic [WIDTH-1:0]             lane_en,
    input  logic [WIDTH*REG_SEL-1:0]     dst,
    input  logic [WIDTH*PHY_REG_SEL-1:0] phy_dst,
    output phys_t                        result
);
    always_comb begin
        result = map_val;
        for (int i = 0; i < WIDTH; i++) begin
            if (lane_en[i] && (dst[i*REG_SEL +: REG_SEL] == query))
                result = phy_dst[i*PHY_REG_SEL +: PHY_REG_SEL];
        end
    end
endmodule

// File: rtl/frontend_rat_ckpt.sv
// N-wide register alias table with committed map for flush recovery and a ring of
// speculative snapshots for single-cycle mispredict recovery.
module frontend_rat_ckpt
    import frontend_rat_ckpt_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    frontend_rat_ckpt_if.slave rat
);
    phys_t spec_map [REG_NUM];
    phys_t cm_map   [REG_NUM];
    phys_t cm_next  [REG_NUM];
    phys_t snap_val [REG_NUM];
    phys_t ckpt_map [NUM_CKPT][REG_NUM];
    phys_t src1_byp [WIDTH];
    phys_t src2_byp [WIDTH];
    phys_t ori_byp  [WIDTH];

    logic [NUM_CKPT-1:0] ckpt_valid, valid_next, mp_clear;
    ckpt_t               tail, tail_next, mp_span;
    logic [WIDTH-1:0]    wr_lane, br_lane, snap_en;
    logic                branch_req, alloc;

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            wr_lane[i] = rat.ren_valid[i] && rat.wr_reg[i] && (rat.dst[i*REG_SEL +: REG_SEL] != '0);
            snap_en[i] = |(br_lane >> i);
        end
        snap_en = snap_en & wr_lane;
    end

    assign br_lane       = rat.ren_valid & rat.is_branch;
    assign branch_req    = |br_lane;
    assign rat.ckpt_full = ckpt_valid[tail];
    assign rat.ckpt_id   = tail;
    assign rat.ren_ready = !(rat.ckpt_full && branch_req) && !rat.flush && !rat.br_mispredict;
    assign alloc         = rat.ren_ready && branch_req;

    for (genvar j = 0; j < WIDTH; j++) begin : g_lane
        localparam logic [WIDTH-1:0] OLDER = WIDTH'((1 << j) - 1);
        arch_t s1, s2, d;
        assign s1 = rat.rs1[j*REG_SEL +: REG_SEL];
        assign s2 = rat.rs2[j*REG_SEL +: REG_SEL];
        assign d  = rat.dst[j*REG_SEL +: REG_SEL];

        rat_group_bypass u_src1 (.query(s1), .map_val(spec_map[s1]), .lane_en(wr_lane & OLDER),
                                 .dst(rat.dst), .phy_dst(rat.phy_dst), .result(src1_byp[j]));
        rat_group_bypass u_src2 (.query(s2), .map_val(spec_map[s2]), .lane_en(wr_lane & OLDER),
                                 .dst(rat.dst), .phy_dst(rat.phy_dst), .result(src2_byp[j]));
        rat_group_bypass u_ori  (.query(d), .map_val(spec_map[d]), .lane_en(wr_lane & OLDER),
                                 .dst(rat.dst), .phy_dst(rat.phy_dst), .result(ori_byp[j]));
    end

    always_comb begin
        for (int j = 0; j < WIDTH; j++) begin
            rat.phy_src1[j*PHY_REG_SEL +: PHY_REG_SEL] =
                (rat.uses_rs1[j] && rat.rs1[j*REG_SEL +: REG_SEL] != '0) ? src1_byp[j] : '0;
            rat.phy_src2[j*PHY_REG_SEL +: PHY_REG_SEL] =
                (rat.uses_rs2[j] && rat.rs2[j*REG_SEL +: REG_SEL] != '0) ? src2_byp[j] : '0;
            rat.phy_ori_dst[j*PHY_REG_SEL +: PHY_REG_SEL] = ori_byp[j];
        end
    end

    // Snapshot excludes lanes younger than the branch lane.
    for (genvar r = 0; r < REG_NUM; r++) begin : g_snap
        rat_group_bypass u_snap (.query(arch_t'(r)), .map_val(spec_map[r]), .lane_en(snap_en),
                                 .dst(rat.dst), .phy_dst(rat.phy_dst), .result(snap_val[r]));
    end

    always_comb begin
        cm_next = cm_map;
        for (int i = 0; i < WIDTH; i++) begin
            if (rat.cm_valid[i] && rat.cm_dst[i*REG_SEL +: REG_SEL] != '0)
                cm_next[rat.cm_dst[i*REG_SEL +: REG_SEL]] = rat.cm_phy[i*PHY_REG_SEL +: PHY_REG_SEL];
        end
    end

    // Mispredict kills id..tail-1; id == tail means the whole ring is younger.
    always_comb begin
        mp_span = tail - rat.br_mispredict_id;
        for (int k = 0; k < NUM_CKPT; k++)
            mp_clear[k] = (mp_span == '0) || (ckpt_t'(ckpt_t'(k) - rat.br_mispredict_id) < mp_span);

        valid_next = ckpt_valid;
        tail_next  = tail;
        if (rat.br_resolve)
            valid_next[rat.br_resolve_id] = 1'b0;
        if (rat.br_mispredict) begin
            valid_next = valid_next & ~mp_clear;
            tail_next  = rat.br_mispredict_id;
        end
        if (alloc) begin
            valid_next[tail] = 1'b1;
            tail_next        = tail + 1'b1;
        end
        if (rat.flush) begin
            valid_next = '0;
            tail_next  = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < REG_NUM; r++) begin
                spec_map[r] <= phys_t'(r);
                cm_map[r]   <= phys_t'(r);
            end
            ckpt_valid <= '0;
            tail       <= '0;
        end else begin
            cm_map     <= cm_next;
            ckpt_valid <= valid_next;
            tail       <= tail_next;
            if (rat.flush)
                spec_map <= cm_next;
            else if (rat.br_mispredict)
                spec_map <= ckpt_map[rat.br_mispredict_id];
            else if (rat.ren_ready) begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (wr_lane[i])
                        spec_map[rat.dst[i*REG_SEL +: REG_SEL]] <= rat.phy_dst[i*PHY_REG_SEL +: PHY_REG_SEL];
                end
            end
        end
    end

    // Snapshot contents are only meaningful while their valid bit is set.
    always_ff @(posedge clk) begin
        if (alloc)
            ckpt_map[tail] <= snap_val;
    end
endmodule

// File: tb/tb_frontend_rat_ckpt.sv
// Directed checks of rename bypass, checkpoint allocate/restore, commit and flush.
module tb_frontend_rat_ckpt;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    frontend_rat_ckpt_if bus ();
    frontend_rat_ckpt dut (.clk(clk), .reset(reset), .rat(bus.slave));

    task automatic idle();
        bus.ren_valid = '0; bus.rs1 = '0; bus.rs2 = '0; bus.uses_rs1 = '0; bus.uses_rs2 = '0;
        bus.dst = '0; bus.wr_reg = '0; bus.phy_dst = '0; bus.is_branch = '0;
        bus.br_resolve = 1'b0; bus.br_resolve_id = '0;
        bus.br_mispredict = 1'b0; bus.br_mispredict_id = '0;
        bus.cm_valid = '0; bus.cm_dst = '0; bus.cm_phy = '0; bus.flush = 1'b0;
    endtask

    // r1/r2 < 0 marks the source unused.
    task automatic lane(input int l, input int r1, input int r2, input int d,
                        input bit wr, input int p, input bit br);
        bus.ren_valid[l] = 1'b1;
        bus.uses_rs1[l] = (r1 >= 0);
        bus.uses_rs2[l] = (r2 >= 0);
        bus.rs1[l*5 +: 5] = (r1 >= 0) ? 5'(r1) : 5'd0;
        bus.rs2[l*5 +: 5] = (r2 >= 0) ? 5'(r2) : 5'd0;
        bus.dst[l*5 +: 5] = 5'(d);
        bus.wr_reg[l] = wr;
        bus.phy_dst[l*6 +: 6] = 6'(p);
        bus.is_branch[l] = br;
    endtask

    task automatic commit(input int l, input int d, input int p);
        bus.cm_valid[l] = 1'b1;
        bus.cm_dst[l*5 +: 5] = 5'(d);
        bus.cm_phy[l*6 +: 6] = 6'(p);
    endtask

    function automatic logic [31:0] src1(input int l);
        return 32'(bus.phy_src1[l*6 +: 6]);
    endfunction
    function automatic logic [31:0] src2(input int l);
        return 32'(bus.phy_src2[l*6 +: 6]);
    endfunction
    function automatic logic [31:0] ori(input int l);
        return 32'(bus.phy_ori_dst[l*6 +: 6]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic next();
        @(negedge clk);
        idle();
    endtask

    initial begin
        idle();
        settle();
        chk("reset_full", 32'(bus.ckpt_full), 0);
        chk("reset_ckpt_id", 32'(bus.ckpt_id), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // identity map after reset
        next(); lane(0, 5, -1, 7, 1'b0, 0, 1'b0); settle();
        chk("id_src1", src1(0), 5);
        chk("id_ori", ori(0), 7);
        chk("unused_src2", src2(0), 0);
        chk("ready_idle", 32'(bus.ren_ready), 1);

        // intra-group bypass
        next(); lane(0, -1, -1, 3, 1'b1, 40, 1'b0); lane(1, 3, -1, 3, 1'b0, 45, 1'b0); settle();
        chk("byp_src1", src1(1), 40);
        chk("byp_ori", ori(1), 40);
        chk("byp_ori_l0", ori(0), 3);
        next(); lane(0, 3, -1, 0, 1'b0, 0, 1'b0); settle();
        chk("x3_written", src1(0), 40);

        // equal dst across lanes: highest lane wins
        next(); lane(0, -1, -1, 6, 1'b1, 20, 1'b0); lane(1, -1, -1, 6, 1'b1, 21, 1'b0); settle();
        next(); lane(0, 6, -1, 0, 1'b0, 0, 1'b0); settle();
        chk("x6_hi_lane", src1(0), 21);

        // branch on lane 0 snapshots before lane 1's write
        next(); lane(0, -1, -1, 4, 1'b1, 41, 1'b1); lane(1, -1, -1, 4, 1'b1, 42, 1'b0); settle();
        chk("br_ckpt_id", 32'(bus.ckpt_id), 0);
        chk("br_ready", 32'(bus.ren_ready), 1);
        next(); lane(0, 4, -1, 0, 1'b0, 0, 1'b0); settle();
        chk("x4_spec", src1(0), 42);
        chk("tail_after_br", 32'(bus.ckpt_id), 1);
        next(); bus.br_mispredict = 1'b1; bus.br_mispredict_id = 2'd0;
        lane(0, -1, -1, 5, 1'b1, 60, 1'b0); settle();
        chk("mp_ready", 32'(bus.ren_ready), 0);
        next(); lane(0, 4, 6, 0, 1'b0, 0, 1'b0); lane(1, 5, -1, 0, 1'b0, 0, 1'b0); settle();
        chk("mp_x4", src1(0), 41);
        chk("mp_x6", src2(0), 21);
        chk("mp_x5_suppr", src1(1), 5);
        chk("mp_tail", 32'(bus.ckpt_id), 0);
        chk("mp_full", 32'(bus.ckpt_full), 0);

        // fill the ring
        for (int k = 0; k < 4; k++) begin
            next(); lane(0, -1, -1, 8, 1'b1, 30 + k, 1'b1); settle();
            chk("fill_id", 32'(bus.ckpt_id), 32'(k));
            chk("fill_ready", 32'(bus.ren_ready), 1);
        end
        next(); lane(0, -1, -1, 8, 1'b1, 39, 1'b1); settle();
        chk("full_flag", 32'(bus.ckpt_full), 1);
        chk("full_stall", 32'(bus.ren_ready), 0);
        next(); bus.br_resolve = 1'b1; bus.br_resolve_id = 2'd0;
        lane(0, 8, -1, 0, 1'b0, 0, 1'b0); settle();
        chk("full_x8", src1(0), 33);
        next(); settle();
        chk("resolve_full", 32'(bus.ckpt_full), 0);
        lane(0, -1, -1, 8, 1'b1, 38, 1'b1); settle();
        chk("realloc_ready", 32'(bus.ren_ready), 1);
        chk("realloc_id", 32'(bus.ckpt_id), 0);
        next(); lane(0, 8, -1, 0, 1'b0, 0, 1'b0); settle();
        chk("realloc_x8", src1(0), 38);
        chk("realloc_tail", 32'(bus.ckpt_id), 1);
        chk("realloc_full", 32'(bus.ckpt_full), 1);
        // mispredict id 2 with tail 1 wraps and clears 2,3,0
        next(); bus.br_mispredict = 1'b1; bus.br_mispredict_id = 2'd2; settle();
        next(); lane(0, 8, 4, 0, 1'b0, 0, 1'b0); settle();
        chk("wrap_x8", src1(0), 32);
        chk("wrap_x4", src2(0), 41);
        chk("wrap_tail", 32'(bus.ckpt_id), 2);
        chk("wrap_full", 32'(bus.ckpt_full), 0);

        // commit, rename, then flush with same-cycle commit
        next(); commit(0, 9, 50); lane(0, -1, -1, 9, 1'b1, 51, 1'b0); settle();
        next(); lane(0, 9, -1, 0, 1'b0, 0, 1'b0); settle();
        chk("x9_spec", src1(0), 51);
        next(); bus.flush = 1'b1; commit(1, 10, 52); commit(0, 11, 53);
        lane(0, -1, -1, 12, 1'b1, 60, 1'b1); settle();
        chk("flush_ready", 32'(bus.ren_ready), 0);
        next(); commit(0, 11, 55); commit(1, 11, 54); bus.flush = 1'b1; settle();
        next(); lane(0, 9, 10, 0, 1'b0, 0, 1'b0); lane(1, 8, 12, 0, 1'b0, 0, 1'b0); settle();
        chk("flush_x9", src1(0), 50);
        chk("flush_x10", src2(0), 52);
        chk("flush_x8", src1(1), 8);
        chk("flush_x12", src2(1), 12);
        chk("flush_full", 32'(bus.ckpt_full), 0);
        chk("flush_tail", 32'(bus.ckpt_id), 0);
        next(); lane(0, 11, -1, 0, 1'b0, 0, 1'b0); settle();
        chk("cm_hi_lane", src1(0), 54);

        // register 0 never written or bypassed
        next(); lane(0, -1, -1, 0, 1'b1, 61, 1'b0); lane(1, 0, 0, 0, 1'b1, 62, 1'b0); settle();
        chk("x0_src1", src1(1), 0);
        chk("x0_ori_l1", ori(1), 0);
        next(); lane(0, 0, -1, 0, 1'b0, 0, 1'b0); settle();
        chk("x0_map", ori(0), 0);

        // reset mid-operation
        next(); lane(0, -1, -1, 9, 1'b1, 63, 1'b1); settle();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        idle(); lane(0, 9, 3, 0, 1'b0, 0, 1'b0); settle();
        chk("rst_x9", src1(0), 9);
        chk("rst_x3", src2(0), 3);
        chk("rst_full", 32'(bus.ckpt_full), 0);
        chk("rst_tail", 32'(bus.ckpt_id), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/frontend_rat_ckpt.md
Name: frontend_rat_ckpt

Overview:
- Parametrised N-wide register alias table for the rename stage.
- Maps architectural sources and destinations to physical registers, with intra-group bypass.
- Keeps a committed map for full-flush recovery.
- Keeps NUM_CKPT speculative snapshots for single-cycle branch-mispredict recovery.
- Sits between decode/free-list allocation and the ROB/issue dispatch logic.

Parameters:
- WIDTH, 2: rename/commit lanes per cycle.
- REG_NUM, 32: architectural registers; register 0 is hardwired zero.
- REG_SEL, 5: log2(REG_NUM).
- PHY_REG_SEL, 6: physical register index width.
- NUM_CKPT, 4: branch checkpoints (power of two).
- CKPT_SEL, 2: log2(NUM_CKPT).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- ren_valid  in  WIDTH  lane carries a real instruction
- rs1, rs2  in  WIDTH*REG_SEL  arch sources, lane i at [i*REG_SEL +: REG_SEL]
- uses_rs1, uses_rs2  in  WIDTH  source used
- dst  in  WIDTH*REG_SEL  arch destination
- wr_reg  in  WIDTH  lane writes dst
- phy_dst  in  WIDTH*PHY_REG_SEL  newly allocated physical register
- is_branch  in  WIDTH  lane needs a checkpoint; at most one set per group
- ren_ready  out  1  group accepted this cycle
- phy_src1, phy_src2  out  WIDTH*PHY_REG_SEL  renamed sources
- phy_ori_dst  out  WIDTH*PHY_REG_SEL  previous mapping of dst, for freeing at commit
- ckpt_id  out  CKPT_SEL  id assigned to this group's branch
- br_resolve  in  1  branch resolved correctly
- br_resolve_id  in  CKPT_SEL  checkpoint to release
- br_mispredict  in  1  restore a checkpoint
- br_mispredict_id  in  CKPT_SEL  checkpoint to restore
- cm_valid  in  WIDTH  commit lane valid
- cm_dst  in  WIDTH*REG_SEL  committed arch destination
- cm_phy  in  WIDTH*PHY_REG_SEL  committed physical register
- flush  in  1  full pipeline flush; restore from the committed map
- ckpt_full  out  1  no free checkpoint

Behaviour:
- Reset (async):
  - speculative and committed maps set to identity (arch i -> phys i);
  - all checkpoint valid bits cleared, tail = 0;
  - ckpt_full = 0.
- Reads are combinational, zero latency. For each lane j:
  - source value = the map entry, overridden by the youngest older lane i<j with ren_valid & wr_reg & dst==src;
  - an unused source or source reg 0 outputs 0;
  - phy_ori_dst follows the same bypass rule.
- Register-0 rule: lanes with dst==0 never write any map and never bypass.
- ren_ready = !(ckpt_full && |(ren_valid & is_branch)) && !flush && !br_mispredict.
- Writes: when ren_ready, at posedge every qualifying lane writes the map. On equal dst across lanes, the highest lane wins.
- Checkpoint allocation:
  - allocate only at tail, only when valid[tail]==0, so ckpt_full = valid[tail];
  - the snapshot captures the map after applying lanes 0..b, where b is the branch lane; younger lanes in the group are excluded;
  - on allocation set valid[tail] and increment tail (wraps modulo NUM_CKPT);
  - ckpt_id = tail (combinational).
- br_resolve: clear valid[br_resolve_id]. Releases may occur out of order.
- br_mispredict:
  - speculative map <= ckpt[id];
  - clear valid bits for id through tail-1 in circular order (id and all younger);
  - tail <= id;
  - rename writes in the same cycle are suppressed.
- Commit: every cm_valid lane with cm_dst!=0 writes the committed map; the highest lane wins on conflict.
- flush:
  - speculative map <= committed map including same-cycle commit writes (bypassed);
  - all checkpoint valid bits cleared, tail = 0.
- Priority: reset > flush > br_mispredict > rename writes. br_resolve and commit writes always proceed, except that flush overrides valid-bit updates.
- br_resolve and br_mispredict in the same cycle: mispredict clearing dominates. A resolve outside the cleared range still clears its own bit.
- Reset mid-operation discards all state. No partial group writes persist.

Decomposition:
- Shared package holds REG_SEL, PHY_REG_SEL, CKPT_SEL, REG_NUM, and the arch/phys/ckpt index typedefs.
- One sub-module, rat_group_bypass: combinational per-lane priority bypass. It is reused for the source reads, phy_ori_dst, and the "map after lane b" snapshot value.

Test Plan:
- Reset, then read rs1=5 on lane 0 -> phy_src1 lane 0 = 5; dst 7 gives phy_ori_dst = 7.
- Lane 0 writes x3->40 and lane 1 reads rs1=x3 in the same group -> lane 1 phy_src1 = 40, lane 1 phy_ori_dst(x3) = 40. Next cycle lane 0 reading x3 -> 40.
- Branch on lane 0 (x4->41), lane 1 writes x4->42; later mispredict with that ckpt_id -> x4 reads 41 next cycle, tail equals that id.
- Allocate NUM_CKPT=4 branches without resolve -> ckpt_full=1. A 5th branch group gives ren_ready=0 and the map is unchanged. br_resolve of id 0 -> ckpt_full=0, and allocation succeeds at tail 0.
- Commit x9->50, rename x9->51, then flush in the same cycle as commit x10->52 -> next cycle x9 reads 50, x10 reads 52, ckpt_full=0.
- Writes to x0 in both lanes -> x0 still reads 0 and there is no bypass into a younger lane.
